// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register: forwards both source operands and inserts a bubble on load-use hazards.
// Latency 1 cycle; ex_hold freezes the stage, flush kills the capture, stall_id holds decode.
module idex_operand_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic [3:0]       id_alu_op_i,
    input  logic             id_use_imm_i,
    input  logic             id_mem_read_i,
    input  logic             id_mem_write_i,
    input  logic             id_reg_write_i,
    input  logic [XLEN-1:0]  rf_rd1_i,
    input  logic [XLEN-1:0]  rf_rd2_i,
    input  logic [XLEN-1:0]  ex_result_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             mem_we_i,
    input  logic [XLEN-1:0]  mem_data_i,
    input  logic [4:0]       wb_rd_i,
    input  logic             wb_we_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic             flush_i,
    input  logic             ex_hold_i,
    output logic             stall_id_o,
    output logic             ex_valid_o,
    output logic [4:0]       ex_rd_o,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic [XLEN-1:0]  ex_op1_o,
    output logic [XLEN-1:0]  ex_op2_o,
    output logic [3:0]       ex_alu_op_o,
    output logic             ex_use_imm_o,
    output logic             ex_mem_read_o,
    output logic             ex_mem_write_o,
    output logic             ex_reg_write_o,
    output logic [CNT_W-1:0] lu_bubbles_o
);

    logic             ex_valid_q, ex_valid_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
    logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
    logic [XLEN-1:0]  ex_op1_q, ex_op1_d;
    logic [XLEN-1:0]  ex_op2_q, ex_op2_d;
    logic [3:0]       ex_alu_op_q, ex_alu_op_d;
    logic             ex_use_imm_q, ex_use_imm_d;
    logic             ex_mem_read_q, ex_mem_read_d;
    logic             ex_mem_write_q, ex_mem_write_d;
    logic             ex_reg_write_q, ex_reg_write_d;
    logic [CNT_W-1:0] lu_bubbles_q, lu_bubbles_d;

    logic            ex_fwd_en;
    logic            lu;
    logic [XLEN-1:0] op1_sel, op2_sel;

    // A load in EX has no data yet, so it is never a forwarding source.
    assign ex_fwd_en = ex_valid_q & ex_reg_write_q & ~ex_mem_read_q;

    assign lu = id_valid_i & ex_valid_q & ex_mem_read_q & (ex_rd_q != 5'd0)
              & ((ex_rd_q == id_rs1_i) | (ex_rd_q == id_rs2_i));

    assign stall_id_o = rst_n_i & ~flush_i & (ex_hold_i | lu);

    function automatic logic [XLEN-1:0] sel_operand(input logic [4:0] rs,
                                                    input logic [XLEN-1:0] rf_val);
        if (rs == 5'd0)
            return '0;
        else if (ex_fwd_en && ex_rd_q == rs)
            return ex_result_i;
        else if (mem_we_i && mem_rd_i == rs)
            return mem_data_i;
        else if (wb_we_i && wb_rd_i == rs)
            return wb_data_i;
        else
            return rf_val;
    endfunction

    assign op1_sel = sel_operand(id_rs1_i, rf_rd1_i);
    assign op2_sel = sel_operand(id_rs2_i, rf_rd2_i);

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_rd_d        = ex_rd_q;
        ex_pc_d        = ex_pc_q;
        ex_imm_d       = ex_imm_q;
        ex_op1_d       = ex_op1_q;
        ex_op2_d       = ex_op2_q;
        ex_alu_op_d    = ex_alu_op_q;
        ex_use_imm_d   = ex_use_imm_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_mem_write_d = ex_mem_write_q;
        ex_reg_write_d = ex_reg_write_q;
        lu_bubbles_d   = lu_bubbles_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (ex_hold_i) begin
            ex_valid_d = ex_valid_q;
        end else if (lu) begin
            ex_valid_d = 1'b0;
            if (lu_bubbles_q != '1)
                lu_bubbles_d = lu_bubbles_q + CNT_W'(1);
        end else begin
            ex_valid_d     = id_valid_i;
            ex_rd_d        = id_rd_i;
            ex_pc_d        = id_pc_i;
            ex_imm_d       = id_imm_i;
            ex_op1_d       = op1_sel;
            ex_op2_d       = op2_sel;
            ex_alu_op_d    = id_alu_op_i;
            ex_use_imm_d   = id_use_imm_i;
            ex_mem_read_d  = id_mem_read_i;
            ex_mem_write_d = id_mem_write_i;
            ex_reg_write_d = id_reg_write_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ex_valid_q     <= 1'b0;
            ex_rd_q        <= '0;
            ex_pc_q        <= '0;
            ex_imm_q       <= '0;
            ex_op1_q       <= '0;
            ex_op2_q       <= '0;
            ex_alu_op_q    <= '0;
            ex_use_imm_q   <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_reg_write_q <= 1'b0;
            lu_bubbles_q   <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rd_q        <= ex_rd_d;
            ex_pc_q        <= ex_pc_d;
            ex_imm_q       <= ex_imm_d;
            ex_op1_q       <= ex_op1_d;
            ex_op2_q       <= ex_op2_d;
            ex_alu_op_q    <= ex_alu_op_d;
            ex_use_imm_q   <= ex_use_imm_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            ex_reg_write_q <= ex_reg_write_d;
            lu_bubbles_q   <= lu_bubbles_d;
        end
    end

    assign ex_valid_o     = ex_valid_q;
    assign ex_rd_o        = ex_rd_q;
    assign ex_pc_o        = ex_pc_q;
    assign ex_imm_o       = ex_imm_q;
    assign ex_op1_o       = ex_op1_q;
    assign ex_op2_o       = ex_op2_q;
    assign ex_alu_op_o    = ex_alu_op_q;
    assign ex_use_imm_o   = ex_use_imm_q;
    assign ex_mem_read_o  = ex_mem_read_q;
    assign ex_mem_write_o = ex_mem_write_q;
    assign ex_reg_write_o = ex_reg_write_q;
    assign lu_bubbles_o   = lu_bubbles_q;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed bench for idex_operand_stage; a second instance with a 3-bit counter exercises saturation.
module tb_idex_operand_stage;

    localparam int XLEN = 32;

    localparam int K_VALID = 0, K_RD = 1, K_PC = 2, K_IMM = 3, K_OP1 = 4, K_OP2 = 5,
                   K_ALU = 6, K_CTRL = 7, K_CNT = 8, K_SAT = 9;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] id_pc, id_imm;
    logic [3:0]      id_alu_op;
    logic            id_use_imm, id_mem_read, id_mem_write, id_reg_write;
    logic [XLEN-1:0] rf_rd1, rf_rd2, ex_result;
    logic [4:0]      mem_rd, wb_rd;
    logic            mem_we, wb_we;
    logic [XLEN-1:0] mem_data, wb_data;
    logic            flush, ex_hold;

    logic            stall_id, ex_valid;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_pc, ex_imm, ex_op1, ex_op2;
    logic [3:0]      ex_alu_op;
    logic            ex_use_imm, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [15:0]     lu_bubbles;

    logic            s_stall, s_valid;
    logic [4:0]      s_rd;
    logic [XLEN-1:0] s_pc, s_imm, s_op1, s_op2;
    logic [3:0]      s_alu;
    logic            s_ui, s_mr, s_mw, s_rw;
    logic [2:0]      s_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    idex_operand_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_pc_i(id_pc), .id_imm_i(id_imm), .id_alu_op_i(id_alu_op),
        .id_use_imm_i(id_use_imm), .id_mem_read_i(id_mem_read),
        .id_mem_write_i(id_mem_write), .id_reg_write_i(id_reg_write),
        .rf_rd1_i(rf_rd1), .rf_rd2_i(rf_rd2), .ex_result_i(ex_result),
        .mem_rd_i(mem_rd), .mem_we_i(mem_we), .mem_data_i(mem_data),
        .wb_rd_i(wb_rd), .wb_we_i(wb_we), .wb_data_i(wb_data),
        .flush_i(flush), .ex_hold_i(ex_hold), .stall_id_o(stall_id),
        .ex_valid_o(ex_valid), .ex_rd_o(ex_rd), .ex_pc_o(ex_pc), .ex_imm_o(ex_imm),
        .ex_op1_o(ex_op1), .ex_op2_o(ex_op2), .ex_alu_op_o(ex_alu_op),
        .ex_use_imm_o(ex_use_imm), .ex_mem_read_o(ex_mem_read),
        .ex_mem_write_o(ex_mem_write), .ex_reg_write_o(ex_reg_write),
        .lu_bubbles_o(lu_bubbles)
    );

    idex_operand_stage #(.XLEN(XLEN), .CNT_W(3)) dut_sat (
        .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_pc_i(id_pc), .id_imm_i(id_imm), .id_alu_op_i(id_alu_op),
        .id_use_imm_i(id_use_imm), .id_mem_read_i(id_mem_read),
        .id_mem_write_i(id_mem_write), .id_reg_write_i(id_reg_write),
        .rf_rd1_i(rf_rd1), .rf_rd2_i(rf_rd2), .ex_result_i(ex_result),
        .mem_rd_i(mem_rd), .mem_we_i(mem_we), .mem_data_i(mem_data),
        .wb_rd_i(wb_rd), .wb_we_i(wb_we), .wb_data_i(wb_data),
        .flush_i(flush), .ex_hold_i(ex_hold), .stall_id_o(s_stall),
        .ex_valid_o(s_valid), .ex_rd_o(s_rd), .ex_pc_o(s_pc), .ex_imm_o(s_imm),
        .ex_op1_o(s_op1), .ex_op2_o(s_op2), .ex_alu_op_o(s_alu),
        .ex_use_imm_o(s_ui), .ex_mem_read_o(s_mr),
        .ex_mem_write_o(s_mw), .ex_reg_write_o(s_rw),
        .lu_bubbles_o(s_cnt)
    );

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_VALID: return {31'd0, ex_valid};
            K_RD:    return {27'd0, ex_rd};
            K_PC:    return ex_pc;
            K_IMM:   return ex_imm;
            K_OP1:   return ex_op1;
            K_OP2:   return ex_op2;
            K_ALU:   return {28'd0, ex_alu_op};
            K_CTRL:  return {28'd0, ex_use_imm, ex_mem_read, ex_mem_write, ex_reg_write};
            K_CNT:   return {16'd0, lu_bubbles};
            default: return {29'd0, s_cnt};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int kind, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = v;
        sb.push_back(e);
    endtask

    // Advance one edge, then retire every expectation queued for it.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic check_stall(input string tag, input logic exp);
        #1;
        check(tag, {31'd0, stall_id}, {31'd0, exp});
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [3:0] alu, input logic [3:0] ctrl);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_pc        = pc;
        id_imm       = imm;
        id_alu_op    = alu;
        id_use_imm   = ctrl[3];
        id_mem_read  = ctrl[2];
        id_mem_write = ctrl[1];
        id_reg_write = ctrl[0];
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 4'h0, 4'b0000);
        rf_rd1 = 32'h44; rf_rd2 = 32'h99; ex_result = 32'h0;
        mem_rd = 5'd0; mem_we = 1'b0; mem_data = 32'h0;
        wb_rd = 5'd0; wb_we = 1'b0; wb_data = 32'h0;

        expect_out("rst_valid", K_VALID, 0);
        expect_out("rst_pc", K_PC, 0);
        expect_out("rst_cnt", K_CNT, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // ALU instruction writing x5 enters EX.
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 32'h100, 32'h8, 4'h3, 4'b0001);
        expect_out("a_valid", K_VALID, 1);
        expect_out("a_rd", K_RD, 5);
        expect_out("a_pc", K_PC, 32'h100);
        expect_out("a_imm", K_IMM, 32'h8);
        expect_out("a_alu", K_ALU, 3);
        expect_out("a_ctrl", K_CTRL, 4'b0001);
        expect_out("a_op1_x0", K_OP1, 0);
        expect_out("a_op2_x0", K_OP2, 0);
        tick();

        // Forward priority: EX > MEM > WB > register file.
        ex_result = 32'h11;
        mem_rd = 5'd5; mem_we = 1'b1; mem_data = 32'h22;
        wb_rd = 5'd5; wb_we = 1'b1; wb_data = 32'h33;
        set_id(1'b1, 5'd5, 5'd0, 5'd5, 32'h104, 32'h0, 4'h0, 4'b0000);
        expect_out("fwd_ex", K_OP1, 32'h11);
        tick();
        set_id(1'b1, 5'd5, 5'd0, 5'd6, 32'h108, 32'h0, 4'h0, 4'b0000);
        expect_out("fwd_mem", K_OP1, 32'h22);
        tick();
        mem_we = 1'b0;
        expect_out("fwd_wb", K_OP1, 32'h33);
        tick();
        wb_we = 1'b0;
        expect_out("fwd_rf", K_OP1, 32'h44);
        tick();

        // x0 never forwards even if WB writes it; WB bypass on rs2.
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 32'h10C, 32'h0, 4'h0, 4'b1010);
        expect_out("x0_op1", K_OP1, 0);
        expect_out("x0_ctrl", K_CTRL, 4'b1010);
        tick();
        wb_rd = 5'd7;
        set_id(1'b1, 5'd0, 5'd7, 5'd8, 32'h10C, 32'h0, 4'h0, 4'b0000);
        expect_out("wb_op2", K_OP2, 32'hDEAD);
        tick();
        wb_we = 1'b0;

        // lw x3 then add x4,x3,x1.
        set_id(1'b1, 5'd1, 5'd0, 5'd3, 32'h110, 32'h4, 4'h0, 4'b1101);
        expect_out("lw_ctrl", K_CTRL, 4'b1101);
        expect_out("lw_op1", K_OP1, 32'h44);
        tick();
        rf_rd2 = 32'h55;
        set_id(1'b1, 5'd3, 5'd1, 5'd4, 32'h114, 32'h0, 4'h1, 4'b0001);
        check_stall("lu_stall", 1'b1);
        expect_out("lu_bubble", K_VALID, 0);
        expect_out("lu_cnt", K_CNT, 1);
        expect_out("lu_sat", K_SAT, 1);
        tick();
        mem_rd = 5'd3; mem_we = 1'b1; mem_data = 32'h77;
        check_stall("lu_release", 1'b0);
        expect_out("add_valid", K_VALID, 1);
        expect_out("add_op1_mem", K_OP1, 32'h77);
        expect_out("add_op2_rf", K_OP2, 32'h55);
        expect_out("add_rd", K_RD, 4);
        expect_out("add_cnt", K_CNT, 1);
        tick();

        // Hold three cycles, then flush wins over hold.
        ex_hold = 1'b1;
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 32'h200, 32'h0, 4'h2, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            check_stall("hold_stall", 1'b1);
            expect_out("hold_valid", K_VALID, 1);
            expect_out("hold_pc", K_PC, 32'h114);
            expect_out("hold_op1", K_OP1, 32'h77);
            tick();
        end
        mem_we = 1'b0;
        flush = 1'b1;
        check_stall("flush_hold_stall", 1'b0);
        expect_out("flush_hold_valid", K_VALID, 0);
        tick();
        flush = 1'b0; ex_hold = 1'b0;

        // Flush during a load-use hazard: no stall, no counted bubble.
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 32'h220, 32'h0, 4'h0, 4'b0101);
        expect_out("fl_lw_valid", K_VALID, 1);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 5'd4, 32'h224, 32'h0, 4'h0, 4'b0001);
        flush = 1'b1;
        check_stall("flush_lu_stall", 1'b0);
        expect_out("flush_lu_valid", K_VALID, 0);
        expect_out("flush_lu_cnt", K_CNT, 1);
        tick();
        flush = 1'b0;

        // Eight more hazards via rs2; narrow counter saturates at 7.
        for (int i = 0; i < 8; i++) begin
            set_id(1'b1, 5'd0, 5'd0, 5'd3, 32'h300, 32'h0, 4'h0, 4'b0101);
            expect_out("loop_lw_valid", K_VALID, 1);
            tick();
            set_id(1'b1, 5'd0, 5'd3, 5'd4, 32'h304, 32'h0, 4'h0, 4'b0001);
            check_stall("loop_stall", 1'b1);
            expect_out("loop_bubble", K_VALID, 0);
            expect_out("loop_cnt", K_CNT, 32'(i + 2));
            expect_out("loop_sat", K_SAT, (i + 2 > 7) ? 32'd7 : 32'(i + 2));
            tick();
        end
        set_id(1'b1, 5'd3, 5'd0, 5'd4, 32'h400, 32'h0, 4'h0, 4'b0001);
        expect_out("pre_rst_valid", K_VALID, 1);
        expect_out("pre_rst_cnt", K_CNT, 9);
        tick();

        // Mid-stream reset overrides hold and clears everything.
        rst_n = 1'b0; ex_hold = 1'b1;
        check_stall("rst_stall", 1'b0);
        expect_out("mrst_valid", K_VALID, 0);
        expect_out("mrst_rd", K_RD, 0);
        expect_out("mrst_pc", K_PC, 0);
        expect_out("mrst_op1", K_OP1, 0);
        expect_out("mrst_ctrl", K_CTRL, 0);
        expect_out("mrst_cnt", K_CNT, 0);
        expect_out("mrst_sat", K_SAT, 0);
        tick();
        rst_n = 1'b1; ex_hold = 1'b0;
        set_id(1'b1, 5'd2, 5'd0, 5'd10, 32'h500, 32'h0, 4'h0, 4'b0001);
        expect_out("post_rst_valid", K_VALID, 1);
        expect_out("post_rst_pc", K_PC, 32'h500);
        expect_out("post_rst_op1", K_OP1, 32'h44);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
